pwm_gen: RTL and testbench
==========================

PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of shift register, duty register and counter input.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load  input  1  when high, transfers shift register into duty register.
REQ-005 SHALL have port shift_enable  input  1  when high, shifts S_in into shift register.
REQ-006 SHALL have port S_in  input  1  serial duty-cycle data, MSB first.
REQ-007 SHALL have port counter  input  WIDTH  free-running external PWM counter (0..2^WIDTH-1, wraps).
REQ-008 SHALL have port pwm_signal  output  1  registered PWM output.

Function
REQ-009 SHALL hold internal shift_reg[WIDTH-1:0]; when shift_enable=1 on a rising edge, shift_reg <= {shift_reg[WIDTH-2:0], S_in}; otherwise it holds.
REQ-010 SHALL make a WIDTH-bit value fed MSB first over WIDTH consecutive shift_enable cycles land in shift_reg with bit order preserved.
REQ-011 SHALL hold internal duty_cycle[WIDTH-1:0]; when load=1 on a rising edge, duty_cycle <= shift_reg (value before that edge); otherwise it holds.
REQ-012 SHALL, when load and shift_enable are both high, capture the pre-shift shift_reg into duty_cycle and also perform the shift.
REQ-013 SHALL compute pwm_signal <= (counter < duty_cycle) on every rising edge, unsigned compare, using pre-edge values (one-cycle latency from counter).
REQ-014 SHALL give duty 0 -> pwm_signal constantly 0; duty 2^WIDTH-1 -> high for 2^WIDTH-1 of every 2^WIDTH counter values (never 100%).
REQ-015 SHALL treat counter as an input only; no wrap detection beyond the compare, except as REQ-021 requires.
REQ-016 SHALL leave shift_reg unaffected by load (load does not clear it).

Reset
REQ-017 SHALL, while reset=1 at a rising edge, set shift_reg=0, duty_cycle=0, pwm_signal=0; reset overrides load and shift_enable.
REQ-018 SHALL, on reset asserted mid-shift, discard the partial byte; a new full WIDTH-bit shift is required.
REQ-019 SHALL, when PWM_GEN_SHADOW_EN is defined, also clear the shadow register and its pending flag on reset.

Configuration
REQ-020 SHALL, with macro PWM_GEN_SHADOW_EN undefined, update duty_cycle directly on the load edge per REQ-011.
REQ-021 SHALL, with PWM_GEN_SHADOW_EN defined, store shift_reg into a shadow register and set a pending flag on load; transfer shadow into duty_cycle on the first rising edge where counter == 0 with pending set (including the load edge itself if counter == 0), then clear pending; a later load before transfer overwrites the shadow.

Verification
REQ-022 SHALL cover: reset 15 cycles, shift 0x8C, pulse load -> pwm_signal high exactly 140 of every 256 cycles, rising one cycle after counter==0.
REQ-023 SHALL cover: shift 0x1A then load, and 0xE6 then load -> high 26/256 and 230/256 respectively.
REQ-024 SHALL cover: load 0x00 -> pwm_signal never high; load 0xFF -> low exactly 1 cycle per 256.
REQ-025 SHALL cover: load and shift_enable high together with shift_reg=0xD9 -> duty_cycle=0xD9, shift_reg advances one bit.
REQ-026 SHALL cover: reset asserted after 4 of 8 bits -> shift_reg=0, duty_cycle=0, pwm_signal=0 next cycle.
REQ-027 SHALL cover (PWM_GEN_SHADOW_EN defined): load 0x40 at counter=100 -> old duty persists until counter wraps to 0, then 64/256 high.

Source files
------------

// File: rtl/pwm_gen.sv
// Serial-loaded PWM generator: duty value arrives MSB first through a shift register and is compared against an external counter.
// Optional macro PWM_GEN_SHADOW_EN defers duty updates to the next counter==0 edge via a shadow register.
module pwm_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_enable,
  input  logic             S_in,
  input  logic [WIDTH-1:0] counter,
  output logic             pwm_signal
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;

`ifdef PWM_GEN_SHADOW_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
`endif

  always_comb begin
    shift_d = shift_q;
    duty_d  = duty_q;
    if (shift_enable) begin
      shift_d = {shift_q[WIDTH-2:0], S_in};
    end
`ifdef PWM_GEN_SHADOW_EN
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (load) begin
      shadow_d = shift_q;
      pend_d   = 1'b1;
    end
    // Transfer is allowed on the load edge itself when the counter is already at zero.
    if (pend_d && (counter == '0)) begin
      duty_d = shadow_d;
      pend_d = 1'b0;
    end
`else
    if (load) begin
      duty_d = shift_q;
    end
`endif
    // Compare uses the duty value in force before this edge.
    pwm_d = (counter < duty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
`ifdef PWM_GEN_SHADOW_EN
      shadow_q <= '0;
      pend_q   <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
`ifdef PWM_GEN_SHADOW_EN
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
`endif
    end
  end

  assign pwm_signal = pwm_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: table of duty values checked by high-cycle counts over one counter period,
// plus hand sequences for edge timing, combined load/shift, mid-shift reset and the shadow-register build.
module tb_pwm_gen;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         load;
  logic         shift_enable;
  logic         S_in;
  logic [W-1:0] counter;
  logic         pwm_signal;

  int tests;
  int failures;

  typedef struct {
    logic [W-1:0] value;
    int           exp_high;
    string        name;
  } vec_t;

  vec_t vecs[5];

  pwm_gen #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .shift_enable (shift_enable),
    .S_in         (S_in),
    .counter      (counter),
    .pwm_signal   (pwm_signal)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: inputs change 1 time unit after the edge; the counter is bench-driven and free-running.
  task automatic tick();
    @(posedge clk);
    #1;
    counter = counter + 1'b1;
  endtask

  task automatic shift_bits(input logic [W-1:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      shift_enable = 1'b1;
      S_in         = v[i];
      tick();
    end
    shift_enable = 1'b0;
    S_in         = 1'b0;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic count_high(input int ncycles, output int n);
    n = 0;
    for (int i = 0; i < ncycles; i++) begin
      tick();
      if (pwm_signal) n++;
    end
  endtask

  task automatic wait_counter(input logic [W-1:0] target, input string name);
    int guard;
    guard = 0;
    while (counter != target && guard < 300) begin
      tick();
      guard++;
    end
    if (counter != target) begin
      tests++;
      failures++;
      $display("FAIL %s: counter wait expired, counter=%0d required=%0d", name, counter, target);
    end
  endtask

  // Scoreboard compare
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial begin
    int n;
    int any_high;

    tests    = 0;
    failures = 0;
    reset        = 1'b1;
    load         = 1'b0;
    shift_enable = 1'b0;
    S_in         = 1'b0;
    counter      = '0;

    vecs[0] = '{value: 8'h8C, exp_high: 140, name: "duty_8C"};
    vecs[1] = '{value: 8'h1A, exp_high: 26,  name: "duty_1A"};
    vecs[2] = '{value: 8'hE6, exp_high: 230, name: "duty_E6"};
    vecs[3] = '{value: 8'h00, exp_high: 0,   name: "duty_00"};
    vecs[4] = '{value: 8'hFF, exp_high: 255, name: "duty_FF"};

    // Reset held 15 cycles: output must stay low throughout.
    any_high = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (pwm_signal) any_high++;
    end
    check("reset_pwm_low", any_high, 0);
    reset = 1'b0;

    // Table: shift value, load, one flush edge, then count highs over a full counter period.
    for (int v = 0; v < 5; v++) begin
      shift_bits(vecs[v].value, W);
      pulse_load();
      tick();
      count_high(256, n);
      check(vecs[v].name, n, vecs[v].exp_high);
    end

    // 0x8C edge timing: rises one cycle after counter==0, falls after counter==140.
    shift_bits(8'h8C, W);
    pulse_load();
    tick();
    wait_counter(8'd0, "wait_c0");
    check("pwm_before_wrap", int'(pwm_signal), 0);
    tick();
    check("pwm_rise_after_c0", int'(pwm_signal), 1);
    wait_counter(8'd140, "wait_c140");
    check("pwm_at_c139", int'(pwm_signal), 1);
    tick();
    check("pwm_fall_after_c140", int'(pwm_signal), 0);

    // Load and shift together with shift_reg=0xD9: duty gets 0xD9, shift_reg becomes 0xB3.
    shift_bits(8'hD9, W);
    load         = 1'b1;
    shift_enable = 1'b1;
    S_in         = 1'b1;
    tick();
    load         = 1'b0;
    shift_enable = 1'b0;
    S_in         = 1'b0;
    tick();
    count_high(256, n);
    check("load_shift_duty_D9", n, 217);
    pulse_load();
    tick();
    count_high(256, n);
    check("load_shift_advanced_B3", n, 179);

    // Mid-shift reset: partial bits discarded, duty and output cleared.
    shift_bits(8'hE6, W);
    pulse_load();
    wait_counter(8'd10, "wait_c10");
    shift_bits(8'hFA, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midshift_reset_pwm", int'(pwm_signal), 0);
    count_high(256, n);
    check("midshift_reset_duty_zero", n, 0);
    pulse_load();
    tick();
    count_high(256, n);
    check("midshift_reset_shift_zero", n, 0);
    shift_bits(8'h0F, 4);
    pulse_load();
    tick();
    count_high(256, n);
    check("after_reset_partial_0F", n, 15);

    // Load 0x40 at counter=100 over an old duty of 0xE6.
    shift_bits(8'hE6, W);
    pulse_load();
    tick();
    shift_bits(8'h40, W);
    wait_counter(8'd100, "wait_c100");
    pulse_load();
    count_high(155, n);
`ifdef PWM_GEN_SHADOW_EN
    check("shadow_old_duty_persists", n, 129);
`else
    check("direct_new_duty_immediate", n, 0);
`endif
    count_high(256, n);
    check("duty_40_after_wrap", n, 64);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
